// File: rtl/lemmings_pkg.sv
// rtl/lemmings_pkg.sv - shared state encoding for the lemming walker FSM
package lemmings_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5
  } lemming_state_t;

  localparam lemming_state_t RESET_STATE = WALK_L;

endpackage

// File: rtl/lemmings_3.sv
// rtl/lemmings_3.sv - Moore FSM for a lemming that walks, falls and digs
module lemmings_3
  import lemmings_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging
);

  lemming_state_t state;
  lemming_state_t state_nxt;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WALK_L: begin
        if (!ground)        state_nxt = FALL_L;
        else if (dig)       state_nxt = DIG_L;
        else if (bump_left) state_nxt = WALK_R;
      end
      WALK_R: begin
        if (!ground)         state_nxt = FALL_R;
        else if (dig)        state_nxt = DIG_R;
        else if (bump_right) state_nxt = WALK_L;
      end
      FALL_L: if (ground)  state_nxt = WALK_L;
      FALL_R: if (ground)  state_nxt = WALK_R;
      DIG_L:  if (!ground) state_nxt = FALL_L;
      DIG_R:  if (!ground) state_nxt = FALL_R;
      // Unused encodings fall back to the reset state.
      default: state_nxt = WALK_L;
    endcase
  end

  always_comb begin
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    digging    = 1'b0;
    case (state)
      WALK_L:         walk_left  = 1'b1;
      WALK_R:         walk_right = 1'b1;
      FALL_L, FALL_R: aaah       = 1'b1;
      DIG_L, DIG_R:   digging    = 1'b1;
      default:        walk_left  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_lemmings_3.sv
// tb/tb_lemmings_3.sv - directed self-checking bench for lemmings_3
module tb_lemmings_3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bump_left = 1'b0;
  logic bump_right = 1'b0;
  logic ground = 1'b1;
  logic dig = 1'b0;
  logic walk_left, walk_right, aaah, digging;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [3:0] O_WL  = 4'b1000;
  localparam logic [3:0] O_WR  = 4'b0100;
  localparam logic [3:0] O_FAL = 4'b0010;
  localparam logic [3:0] O_DIG = 4'b0001;

  lemmings_3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .ground     (ground),
    .dig        (dig),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging)
  );

  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then compare outputs 1 time unit later.
  task automatic step(input string tag, input logic r, input logic g, input logic d,
                      input logic bl, input logic br, input logic [3:0] exp);
    logic [3:0] obs;
    rst_n = r; ground = g; dig = d; bump_left = bl; bump_right = br;
    @(posedge clk);
    #1;
    obs = {walk_left, walk_right, aaah, digging};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    //     tag               rst g  dig bl br  expected
    step("reset",            1, 1, 0, 0, 0, O_WL);
    step("wl_ignore_br",     0, 1, 0, 0, 1, O_WL);
    step("wl_bump_left",     0, 1, 0, 1, 0, O_WR);
    step("both_bumps_1",     0, 1, 0, 1, 1, O_WL);
    step("both_bumps_2",     0, 1, 0, 1, 1, O_WR);
    step("both_bumps_3",     0, 1, 0, 1, 1, O_WL);
    step("both_bumps_4",     0, 1, 0, 1, 1, O_WR);
    step("wr_ignore_bl",     0, 1, 0, 1, 0, O_WR);
    step("fall_r_1",         0, 0, 0, 1, 1, O_FAL);
    step("fall_r_2",         0, 0, 0, 1, 1, O_FAL);
    step("land_r",           0, 1, 0, 0, 0, O_WR);
    step("dig_r_start",      0, 1, 1, 0, 0, O_DIG);
    step("dig_r_hold",       0, 1, 0, 0, 0, O_DIG);
    step("dig_r_ign_bump",   0, 1, 0, 1, 1, O_DIG);
    step("dig_r_to_fall",    0, 0, 0, 0, 0, O_FAL);
    step("dig_r_land",       0, 1, 0, 0, 0, O_WR);
    step("dig_r_again",      0, 1, 1, 0, 0, O_DIG);
    step("reset_mid_dig",    1, 1, 0, 0, 0, O_WL);
    step("after_reset",      0, 1, 0, 0, 0, O_WL);
    step("prio_fall_l",      0, 0, 1, 1, 0, O_FAL);
    step("fall_l_ign_dig",   0, 0, 1, 1, 1, O_FAL);
    step("land_l",           0, 1, 0, 0, 0, O_WL);
    step("dig_l_start",      0, 1, 1, 1, 0, O_DIG);
    step("dig_l_to_fall",    0, 0, 0, 0, 0, O_FAL);
    step("dig_l_land",       0, 1, 0, 0, 0, O_WL);
    step("wl_prio_dig",      0, 1, 1, 1, 0, O_DIG);
    step("dig_l_fall2",      0, 0, 0, 0, 0, O_FAL);
    step("reset_mid_fall",   1, 0, 1, 1, 1, O_WL);
    step("wl_after_rst",     0, 1, 0, 0, 0, O_WL);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lemmings_3.md
LEMMINGS_3 -- requirements
Module: lemmings_3

Interface
REQ-001 The port list SHALL be as follows: clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 The port list SHALL be as follows: rst_n  input  1  synchronous, active-high reset (asserted when 1, sampled on rising clk).
REQ-003 The port list SHALL be as follows: bump_left  input  1  obstacle struck on left side.
REQ-004 The port list SHALL be as follows: bump_right  input  1  obstacle struck on right side.
REQ-005 The port list SHALL be as follows: ground  input  1  1 = ground present under lemming, 0 = no ground.
REQ-006 The port list SHALL be as follows: dig  input  1  request to start digging.
REQ-007 The port list SHALL be as follows: walk_left  output  1  lemming walking left.
REQ-008 The port list SHALL be as follows: walk_right  output  1  lemming walking right.
REQ-009 The port list SHALL be as follows: aaah  output  1  lemming falling.
REQ-010 The port list SHALL be as follows: digging  output  1  lemming digging.

Function
REQ-011 The block SHALL be a Moore FSM with six states: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R; outputs depend only on current state.
REQ-012 Outputs SHALL decode as follows: WALK_L -> walk_left=1; WALK_R -> walk_right=1; FALL_L/FALL_R -> aaah=1; DIG_L/DIG_R -> digging=1; all other outputs 0, exactly one output high at any time.
REQ-013 WALK_L SHALL follow this priority: ground=0 -> FALL_L; else dig=1 -> DIG_L; else bump_left=1 -> WALK_R; else stay.
REQ-014 WALK_R SHALL follow this priority: ground=0 -> FALL_R; else dig=1 -> DIG_R; else bump_right=1 -> WALK_L; else stay.
REQ-015 In WALK_L, bump_right SHALL be ignored; in WALK_R, bump_left SHALL be ignored. With both bumps=1 every cycle, the lemming SHALL reverse direction every cycle.
REQ-016 FALL_L SHALL go to WALK_L when ground=1 and otherwise stay; FALL_R SHALL go to WALK_R when ground=1 and otherwise stay.
REQ-017 DIG_L SHALL go to FALL_L when ground=0 and otherwise stay; DIG_R SHALL go to FALL_R when ground=0 and otherwise stay.
REQ-018 bump_left, bump_right and dig SHALL be ignored while falling or digging; direction SHALL be preserved through fall and dig.
REQ-019 Latency SHALL be one clock: an input sampled at a rising edge changes outputs immediately after that edge, with no combinational input-to-output path.
REQ-020 The state register SHALL never hold an unused encoding; any illegal encoding SHALL recover to WALK_L on the next edge.

Reset
REQ-021 rst_n=1 at a rising edge SHALL force state WALK_L (walk_left=1, walk_right=0, aaah=0, digging=0) regardless of other inputs, including mid-fall or mid-dig.
REQ-022 Reset SHALL be synchronous only, and the block SHALL have no asynchronous clear.

Structure
REQ-023 The state encoding, six states with a 3-bit localparam/enum, SHALL reside in the shared package lemmings_pkg.
REQ-024 The block SHALL be a single module with no sub-module, containing a state register and combinational next-state and output decode.

Verification
REQ-025 The bench SHALL cover this reset scenario: assert rst_n=1 for one edge with ground=1 -> walk_left=1, all other outputs 0.
REQ-026 The bench SHALL cover bump reversal: from WALK_L, pulse bump_right=1 -> stays walk_left; then bump_left=1 -> walk_right=1 next cycle; hold both bumps=1 for 4 cycles -> walk_left/walk_right alternate every cycle.
REQ-027 The bench SHALL cover a fall: from WALK_R, ground=0 for 2 cycles -> aaah=1 while ground=0 and bumps ignored; ground=1 -> walk_right=1 next cycle.
REQ-028 The bench SHALL cover dig then fall: from WALK_R with ground=1, dig=1 one cycle -> digging=1; dig=0 keeps digging; ground=0 -> aaah=1; ground=1 -> walk_right=1.
REQ-029 The bench SHALL cover priority: in WALK_L, apply ground=0, dig=1 and bump_left=1 together -> FALL_L (aaah=1), not dig or reverse.
REQ-030 The bench SHALL cover reset mid-dig: assert rst_n=1 while in DIG_R -> walk_left=1 next cycle.
